// File: rtl/uart_tx_cfg.sv
// UART transmitter with a one-entry holding register and an internal baud counter.
// Frame format (data width, parity, stop bits) is fixed by parameters.
module uart_tx_cfg #(
    parameter int CLKS_PER_BIT = 868,
    parameter int DATA_BITS    = 8,
    parameter int PARITY       = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 s_valid,
    output logic                 s_ready,
    input  logic [DATA_BITS-1:0] s_data,
    output logic                 tx,
    output logic                 busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
    localparam logic          PAR_ODD   = (PARITY == 2);

    generate
        if (CLKS_PER_BIT < 2 || DATA_BITS < 5 || DATA_BITS > 9 ||
            PARITY < 0 || PARITY > 2 ||
            (STOP_BITS != 1 && STOP_BITS != 2)) begin : g_bad_param
            $error("uart_tx_cfg: illegal parameter value");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    state_t               state, state_n;
    logic [CW-1:0]        baud_cnt, baud_n;
    logic [BW-1:0]        bit_cnt, bit_n;
    logic [DATA_BITS-1:0] shift_reg, shift_n;
    logic [DATA_BITS-1:0] hold_data, hold_data_n;
    logic                 hold_valid, hold_valid_n;
    logic                 par_bit, par_n;
    logic                 tx_n, busy_n, ready_n;
    logic                 tick, load;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            baud_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            hold_data  <= '0;
            hold_valid <= 1'b0;
            par_bit    <= 1'b0;
            tx         <= 1'b1;
            busy       <= 1'b0;
            s_ready    <= 1'b1;
        end else begin
            state      <= state_n;
            baud_cnt   <= baud_n;
            bit_cnt    <= bit_n;
            shift_reg  <= shift_n;
            hold_data  <= hold_data_n;
            hold_valid <= hold_valid_n;
            par_bit    <= par_n;
            tx         <= tx_n;
            busy       <= busy_n;
            s_ready    <= ready_n;
        end
    end

    always_comb begin
        state_n      = state;
        baud_n       = baud_cnt;
        bit_n        = bit_cnt;
        shift_n      = shift_reg;
        hold_data_n  = hold_data;
        hold_valid_n = hold_valid;
        par_n        = par_bit;
        tx_n         = tx;
        load         = 1'b0;
        tick         = (baud_cnt == LAST_CNT);

        if (state != IDLE) begin
            baud_n = tick ? '0 : baud_cnt + 1'b1;
        end

        unique case (state)
            IDLE: begin
                baud_n = '0;
                if (hold_valid) load = 1'b1;
            end
            START: begin
                if (tick) begin
                    tx_n    = shift_reg[0];
                    shift_n = shift_reg >> 1;
                    bit_n   = '0;
                    state_n = DATA;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_cnt == LAST_BIT) begin
                        bit_n = '0;
                        if (PARITY != 0) begin
                            state_n = PAR;
                            tx_n    = par_bit;
                        end else begin
                            state_n = STOP;
                            tx_n    = 1'b1;
                        end
                    end else begin
                        tx_n    = shift_reg[0];
                        shift_n = shift_reg >> 1;
                        bit_n   = bit_cnt + 1'b1;
                    end
                end
            end
            PAR: begin
                if (tick) begin
                    state_n = STOP;
                    tx_n    = 1'b1;
                    bit_n   = '0;
                end
            end
            STOP: begin
                if (tick) begin
                    if (bit_cnt == LAST_STOP) begin
                        bit_n = '0;
                        if (hold_valid) load = 1'b1;
                        else state_n = IDLE;
                    end else begin
                        bit_n = bit_cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        // Holding register feeds the shifter; parity comes from the loaded word.
        if (load) begin
            state_n      = START;
            tx_n         = 1'b0;
            baud_n       = '0;
            bit_n        = '0;
            shift_n      = hold_data;
            par_n        = (^hold_data) ^ PAR_ODD;
            hold_valid_n = 1'b0;
        end

        if (s_valid && s_ready) begin
            hold_data_n  = s_data;
            hold_valid_n = 1'b1;
        end

        busy_n  = (state_n != IDLE) || hold_valid_n;
        ready_n = !hold_valid_n;
    end

endmodule

// File: tb/tb_uart_tx_cfg.sv
// Scoreboard bench for uart_tx_cfg: five instances cover 8N1, 8E1, 8O1,
// 7N2 and the full-rate 868-clock configuration.
module tb_uart_tx_cfg;

    typedef struct {
        int          id;
        logic [15:0] frame;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [4:0] sv  = '0;
    logic [8:0] sd [5];
    wire  [4:0] rdy, bsy, txl;

    exp_t expq[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst(rst), .s_valid(sv[0]), .s_ready(rdy[0]),
        .s_data(sd[0][7:0]), .tx(txl[0]), .busy(bsy[0]));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1)) dut1 (
        .clk(clk), .rst(rst), .s_valid(sv[1]), .s_ready(rdy[1]),
        .s_data(sd[1][7:0]), .tx(txl[1]), .busy(bsy[1]));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut2 (
        .clk(clk), .rst(rst), .s_valid(sv[2]), .s_ready(rdy[2]),
        .s_data(sd[2][7:0]), .tx(txl[2]), .busy(bsy[2]));
    uart_tx_cfg #(.CLKS_PER_BIT(4), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) dut3 (
        .clk(clk), .rst(rst), .s_valid(sv[3]), .s_ready(rdy[3]),
        .s_data(sd[3][6:0]), .tx(txl[3]), .busy(bsy[3]));
    uart_tx_cfg #(.CLKS_PER_BIT(868), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut4 (
        .clk(clk), .rst(rst), .s_valid(sv[4]), .s_ready(rdy[4]),
        .s_data(sd[4][7:0]), .tx(txl[4]), .busy(bsy[4]));

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic to_cyc(input int t);
        while (cyc < t) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Called at posedge+1; returns at accept edge +1 with n = accept edge.
    task automatic send(input int id, input logic [8:0] data,
                        input logic [15:0] frame, input bit push, output int n);
        logic r;
        bit   done;
        done = 0;
        n    = 0;
        if (push) expq.push_back('{id, frame});
        sd[id] = data;
        sv[id] = 1'b1;
        for (int i = 0; i < 20000 && !done; i++) begin
            r = rdy[id];
            @(posedge clk);
            #1;
            if (r) begin
                n    = cyc;
                done = 1;
            end
        end
        sv[id] = 1'b0;
        if (!done) chk("send_timeout", 0, 1);
    endtask

    // Receiver model: each bit must hold one level for exactly cpb cycles.
    task automatic mon(input int id, input int cpb, input int nb);
        logic [15:0] got;
        logic        lvl;
        bit          ok, ab;
        exp_t        e;
        forever begin
            @(negedge clk);
            if (!rst && txl[id] == 1'b0) begin
                got = '0;
                lvl = 1'b0;
                ok  = 1;
                ab  = 0;
                for (int k = 0; k < nb && !ab; k++) begin
                    for (int c = 0; c < cpb; c++) begin
                        if (k != 0 || c != 0) @(negedge clk);
                        if (rst) begin
                            ab = 1;
                            break;
                        end
                        if (c == 0) lvl = txl[id];
                        else if (txl[id] != lvl) ok = 0;
                    end
                    got[k] = lvl;
                end
                if (!ab) begin
                    checks++;
                    if (expq.size() == 0) begin
                        failures++;
                        $display("FAIL frame dut%0d: got unexpected frame %h", id, got);
                    end else begin
                        e = expq.pop_front();
                        if (e.id != id || got != e.frame || !ok) begin
                            failures++;
                            $display("FAIL frame dut%0d: got %h steady=%0d required dut%0d %h",
                                     id, got, ok, e.id, e.frame);
                        end
                    end
                end
            end
        end
    endtask

    initial begin
        fork
            mon(0, 4, 10);
            mon(1, 4, 11);
            mon(2, 4, 11);
            mon(3, 4, 10);
            mon(4, 868, 10);
        join_none
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n, m;
        bit bad;
        for (int i = 0; i < 5; i++) sd[i] = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_tx", int'(txl[0]), 1);
        chk("rst_busy", int'(bsy[0]), 0);
        chk("rst_ready", int'(rdy[0]), 1);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset mid-frame with a word pending in the holding register.
        send(0, 9'h0A5, 16'h0, 0, n);
        send(0, 9'h03C, 16'h0, 0, m);
        to_cyc(n + 10);
        #1;
        rst = 1'b1;
        #1;
        chk("midrst_tx", int'(txl[0]), 1);
        chk("midrst_busy", int'(bsy[0]), 0);
        chk("midrst_ready", int'(rdy[0]), 1);
        to_cyc(cyc + 2);
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            @(posedge clk);
            #1;
            if (txl[0] != 1'b1 || bsy[0] != 1'b0) bad = 1;
        end
        chk("post_rst_idle", int'(bad), 0);

        // 0xA5 8N1: start falls one edge after accept, busy falls 41 edges after.
        send(0, 9'h0A5, 16'h034A, 1, n);
        chk("a5_tx_at_accept", int'(txl[0]), 1);
        chk("a5_busy_at_accept", int'(bsy[0]), 1);
        to_cyc(n + 1);
        chk("a5_start", int'(txl[0]), 0);
        to_cyc(n + 40);
        chk("a5_busy_n40", int'(bsy[0]), 1);
        to_cyc(n + 41);
        chk("a5_busy_n41", int'(bsy[0]), 0);
        to_cyc(cyc + 5);

        // Back-to-back 0x55 then 0xAA.
        send(0, 9'h055, 16'h02AA, 1, n);
        send(0, 9'h0AA, 16'h0354, 1, m);
        chk("b2b_accept_edge", m, n + 2);
        chk("b2b_ready_low", int'(rdy[0]), 0);
        bad = 0;
        while (cyc < n + 40) begin
            @(posedge clk);
            #1;
            if (rdy[0] != 1'b0 || bsy[0] != 1'b1) bad = 1;
        end
        chk("b2b_ready_held", int'(bad), 0);
        chk("b2b_stop_level", int'(txl[0]), 1);
        to_cyc(n + 41);
        chk("b2b_ready_back", int'(rdy[0]), 1);
        chk("b2b_no_gap", int'(txl[0]), 0);
        bad = 0;
        while (cyc < n + 80) begin
            if (bsy[0] != 1'b1) bad = 1;
            @(posedge clk);
            #1;
        end
        chk("b2b_busy_held", int'(bad), 0);
        to_cyc(n + 81);
        chk("b2b_busy_fall", int'(bsy[0]), 0);
        to_cyc(cyc + 5);

        // Parity frames, 44 cycles each.
        send(1, 9'h007, 16'h060E, 1, n);
        to_cyc(n + 44);
        chk("e07_busy_n44", int'(bsy[1]), 1);
        to_cyc(n + 45);
        chk("e07_busy_n45", int'(bsy[1]), 0);
        send(2, 9'h007, 16'h040E, 1, n);
        to_cyc(n + 45);
        chk("o07_busy_n45", int'(bsy[2]), 0);
        send(1, 9'h000, 16'h0400, 1, n);
        to_cyc(n + 45);
        chk("e00_busy_n45", int'(bsy[1]), 0);
        to_cyc(cyc + 3);

        // 7N2, 40-cycle frame with 8 stop cycles.
        send(3, 9'h07F, 16'h03FE, 1, n);
        to_cyc(n + 33);
        chk("7n2_stop_start", int'(txl[3]), 1);
        to_cyc(n + 40);
        chk("7n2_busy_n40", int'(bsy[3]), 1);
        to_cyc(n + 41);
        chk("7n2_busy_n41", int'(bsy[3]), 0);
        to_cyc(cyc + 3);

        // Full-rate 0x00: 7812 low cycles, 8680-cycle frame.
        send(4, 9'h000, 16'h0200, 1, n);
        to_cyc(n + 7812);
        chk("fr_last_low", int'(txl[4]), 0);
        to_cyc(n + 7813);
        chk("fr_stop_high", int'(txl[4]), 1);
        to_cyc(n + 8680);
        chk("fr_busy_n8680", int'(bsy[4]), 1);
        to_cyc(n + 8681);
        chk("fr_busy_n8681", int'(bsy[4]), 0);

        to_cyc(cyc + 20);
        chk("queue_empty", expq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
